// File: rtl/syn_counter_ctrl_pkg.sv
// Shared definitions for the counter sequencer: FSM state encoding and the
// direction and mode values of the command fields.
package syn_counter_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic DIR_UP       = 1'b0;
    localparam logic DIR_DOWN     = 1'b1;
    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_RELOAD  = 1'b1;

endpackage

// File: rtl/updown_count_core.sv
// Synchronous up/down counter built as a T-flip-flop toggle chain.
// A load takes priority over a count enable.
module updown_count_core #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             down,
    output logic [WIDTH-1:0] Q
);

    logic [WIDTH-1:0] toggle;

    // Bit i toggles when every lower bit is 1 (up) or 0 (down).
    always_comb begin
        toggle    = '0;
        toggle[0] = 1'b1;
        for (int unsigned i = 1; i < WIDTH; i++) begin
            toggle[i] = toggle[i-1] & (Q[i-1] ^ down);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            Q <= '0;
        end else if (load) begin
            Q <= load_val;
        end else if (en) begin
            Q <= Q ^ toggle;
        end
    end

endmodule

// File: rtl/syn_counter_ctrl.sv
// Counter sequencer: accepts a counting job over valid/ready, loads the start
// value, steps at a prescaled rate and flags terminal count (one-shot or reload).
module syn_counter_ctrl
    import syn_counter_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned PRE_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_start,
    input  logic [WIDTH-1:0] cmd_limit,
    input  logic             cmd_down,
    input  logic             cmd_reload,
    input  logic [PRE_W-1:0] cmd_div,
    input  logic             abort,
    output logic [WIDTH-1:0] Q,
    output logic             busy,
    output logic             tc_pulse,
    output logic             done
);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] cap_start, cap_limit;
    logic             cap_down, cap_reload;
    logic [PRE_W-1:0] cap_div, presc;
    logic             accept, tick, at_limit;
    logic             core_load, core_en, tc_nxt;

    assign cmd_ready = (state == ST_IDLE) && !abort;
    assign accept    = cmd_valid && cmd_ready;
    assign tick      = (state == ST_RUN) && (presc == cap_div);
    assign at_limit  = (Q == cap_limit);
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);

    // Abort outranks any tick or terminal count in the same cycle.
    always_comb begin
        state_nxt = state;
        core_load = 1'b0;
        core_en   = 1'b0;
        tc_nxt    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (accept) state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else begin
                    core_load = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else if (tick) begin
                    if (at_limit) begin
                        tc_nxt = 1'b1;
                        if (cap_reload == MODE_RELOAD) core_load = 1'b1;
                        else                           state_nxt = ST_DONE;
                    end else begin
                        core_en = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            tc_pulse <= 1'b0;
        end else begin
            state    <= state_nxt;
            tc_pulse <= tc_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc <= '0;
        end else if ((abort && state != ST_IDLE) || state == ST_LOAD) begin
            presc <= '0;
        end else if (state == ST_RUN) begin
            presc <= tick ? '0 : presc + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cap_start  <= '0;
            cap_limit  <= '0;
            cap_down   <= DIR_UP;
            cap_reload <= MODE_ONESHOT;
            cap_div    <= '0;
        end else if (accept) begin
            cap_start  <= cmd_start;
            cap_limit  <= cmd_limit;
            cap_down   <= cmd_down;
            cap_reload <= cmd_reload;
            cap_div    <= cmd_div;
        end
    end

    updown_count_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (core_load),
        .load_val(cap_start),
        .en      (core_en),
        .down    (cap_down == DIR_DOWN),
        .Q       (Q)
    );

endmodule
